// File: rtl/fft_se2pa_frame.sv
// fft_se2pa_frame
// Serial-to-parallel frame assembler for FFT output bins. Each accepted beat
// carries one complex bin plus its index. Beats are collected into one of two
// ping-pong banks. A beat with s_tlast closes the frame, which is then offered
// on a parallel valid/ready port together with error and saturation status.
//
// Ports
//   clk, rst                : clock, synchronous active-high reset
//   s_tdata/s_tuser/s_tlast : packed complex bin, bin index, end-of-frame marker
//   s_tvalid/s_tready       : input handshake
//   bin_strobe              : one-hot index of the beat accepted last cycle
//   m_real/m_imag           : N_BINS signed samples, bin k at [k*SAMP_W +: SAMP_W]
//   m_valid/m_ready         : frame handshake
//   m_err                   : frame had a duplicate or a missing bin
//   m_sat                   : a field in the frame was clamped
//
// Build option: define FFT_SE2PA_SAT_EN to clamp fields to SAMP_W instead of
// wrapping them. Clamping events set m_sat; otherwise m_sat is tied to 0.
module fft_se2pa_frame #(
  parameter int N_BINS   = 8,
  parameter int IDX_W    = $clog2(N_BINS),
  parameter int IN_W     = 48,
  parameter int FIELD_W  = 24,
  parameter int REAL_LSB = 0,
  parameter int IMAG_LSB = 24,
  parameter int SAMP_W   = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IN_W-1:0]            s_tdata,
  input  logic [IDX_W-1:0]           s_tuser,
  input  logic                       s_tlast,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  output logic [N_BINS-1:0]          bin_strobe,
  output logic [N_BINS*SAMP_W-1:0]   m_real,
  output logic [N_BINS*SAMP_W-1:0]   m_imag,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       m_err,
  output logic                       m_sat
);

`ifdef FFT_SE2PA_SAT_EN
  localparam logic signed [FIELD_W-1:0] SMAX =
    {{(FIELD_W-SAMP_W+1){1'b0}}, {(SAMP_W-1){1'b1}}};
  localparam logic signed [FIELD_W-1:0] SMIN = ~SMAX;

  function automatic logic signed [SAMP_W-1:0] narrow(input logic signed [FIELD_W-1:0] f);
    if (f > SMAX)      return SAMP_W'(SMAX);
    else if (f < SMIN) return SAMP_W'(SMIN);
    else               return SAMP_W'(f);
  endfunction

  function automatic logic clipped(input logic signed [FIELD_W-1:0] f);
    return (f > SMAX) || (f < SMIN);
  endfunction
`else
  function automatic logic signed [SAMP_W-1:0] narrow(input logic signed [FIELD_W-1:0] f);
    return SAMP_W'(f);
  endfunction
`endif

  logic signed [SAMP_W-1:0] re_q [2][N_BINS];
  logic signed [SAMP_W-1:0] im_q [2][N_BINS];
  logic [N_BINS-1:0]        mask_q [2];
  logic [1:0]               dup_q;
  logic [1:0]               err_q;
  logic [1:0]               full_q;
  logic                     w_sel;
  logic                     r_sel;
  logic [N_BINS-1:0]        strobe_p1;
`ifdef FFT_SE2PA_SAT_EN
  logic [1:0]               sat_q;
`endif

  // ---- stage p0: accept, narrow and classify the incoming beat ----
  logic signed [FIELD_W-1:0] re_fld, im_fld;
  logic signed [SAMP_W-1:0]  re_p0, im_p0;
  logic                      vld_p0;
  logic                      rel_p0;
  logic [N_BINS-1:0]         oh_p0;
  logic [N_BINS-1:0]         mask_nxt;
  logic                      dup_nxt;
  logic                      sat_p0;

  assign s_tready = !full_q[w_sel] && !rst;
  assign vld_p0   = s_tvalid && s_tready;
  assign rel_p0   = full_q[r_sel] && m_ready;

  assign re_fld   = s_tdata[REAL_LSB +: FIELD_W];
  assign im_fld   = s_tdata[IMAG_LSB +: FIELD_W];
  assign re_p0    = narrow(re_fld);
  assign im_p0    = narrow(im_fld);
`ifdef FFT_SE2PA_SAT_EN
  assign sat_p0   = clipped(re_fld) || clipped(im_fld);
`else
  assign sat_p0   = 1'b0;
`endif

  assign oh_p0    = N_BINS'(1) << s_tuser;
  assign mask_nxt = mask_q[w_sel] | oh_p0;
  // A second write to an already filled bin marks the frame as corrupt.
  assign dup_nxt  = dup_q[w_sel] || (|(mask_q[w_sel] & oh_p0));

  // ---- stage p1: bank storage, release and frame close ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < N_BINS; k++) begin
          re_q[b][k] <= '0;
          im_q[b][k] <= '0;
        end
        mask_q[b] <= '0;
      end
      dup_q     <= '0;
      err_q     <= '0;
      full_q    <= '0;
`ifdef FFT_SE2PA_SAT_EN
      sat_q     <= '0;
`endif
      w_sel     <= 1'b0;
      r_sel     <= 1'b0;
      strobe_p1 <= '0;
    end else begin
      strobe_p1 <= vld_p0 ? oh_p0 : '0;

      // Release scrubs the bank so that bins missing from the next frame
      // written into it read back as zero. The open bank is never full, so
      // release and write always touch different banks.
      if (rel_p0) begin
        for (int k = 0; k < N_BINS; k++) begin
          re_q[r_sel][k] <= '0;
          im_q[r_sel][k] <= '0;
        end
        mask_q[r_sel] <= '0;
        dup_q[r_sel]  <= 1'b0;
        err_q[r_sel]  <= 1'b0;
        full_q[r_sel] <= 1'b0;
`ifdef FFT_SE2PA_SAT_EN
        sat_q[r_sel]  <= 1'b0;
`endif
        r_sel         <= ~r_sel;
      end

      if (vld_p0) begin
        re_q[w_sel][s_tuser] <= re_p0;
        im_q[w_sel][s_tuser] <= im_p0;
        mask_q[w_sel]        <= mask_nxt;
        dup_q[w_sel]         <= dup_nxt;
`ifdef FFT_SE2PA_SAT_EN
        sat_q[w_sel]         <= sat_q[w_sel] || sat_p0;
`endif
        if (s_tlast) begin
          full_q[w_sel] <= 1'b1;
          err_q[w_sel]  <= dup_nxt || (mask_nxt != {N_BINS{1'b1}});
          w_sel         <= ~w_sel;
        end
      end
    end
  end

  // ---- output: parallel view of the read bank ----
  always_comb begin
    m_real = '0;
    m_imag = '0;
    for (int k = 0; k < N_BINS; k++) begin
      m_real[k*SAMP_W +: SAMP_W] = re_q[r_sel][k];
      m_imag[k*SAMP_W +: SAMP_W] = im_q[r_sel][k];
    end
  end

  assign bin_strobe = strobe_p1;
  assign m_valid    = full_q[r_sel];
  assign m_err      = full_q[r_sel] && err_q[r_sel];
`ifdef FFT_SE2PA_SAT_EN
  assign m_sat      = full_q[r_sel] && sat_q[r_sel];
`else
  assign m_sat      = 1'b0;
`endif

endmodule
